reaction_timer: RTL and testbench
=================================

REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter MAX_MS, default 5000: largest millisecond value held by any time field; W = $clog2(MAX_MS) bits.
REQ-002 Parameter CLKS_PER_MS, default 50000: clk cycles per millisecond tick.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; arms a trial, already synchronised to clk.
REQ-006 stop  input  1  one-cycle pulse from the player button, already synchronised and debounced.
REQ-007 delay_ms  input  W  pre-stimulus delay; sampled on the accepted start cycle.
REQ-008 timeout_ms  input  W  maximum reaction window; sampled on the accepted start cycle.
REQ-009 stimulus  output  1  high while the player is expected to react (RUN state).
REQ-010 busy  output  1  high in WAIT or RUN.
REQ-011 done  output  1  one-cycle pulse on entry to DONE.
REQ-012 early  output  1  held result flag: stop arrived before stimulus.
REQ-013 timed_out  output  1  held result flag: no stop within timeout_ms.
REQ-014 reaction_ms  output  W  held measured reaction time in ms.
REQ-015 best_ms  output  W  best valid reaction time (see Configuration).

Function
REQ-016 States: IDLE, WAIT, RUN, DONE; the encoding is internal.
REQ-017 Prescaler counts 0..CLKS_PER_MS-1 and raises an internal tick on terminal count; the prescaler clears on an accepted start and when leaving WAIT.
REQ-018 start is accepted only in IDLE or DONE: latch delay_ms and timeout_ms, clear early, timed_out and reaction_ms, then go to WAIT; start is ignored in WAIT and RUN.
REQ-019 WAIT: the delay counter, loaded with the latched delay, decrements on each tick; when the tick arrives with the counter at 1, go to RUN the next cycle; a latched delay of 0 goes to RUN one cycle after start.
REQ-020 RUN: stimulus=1; the elapsed counter starts at 0 and increments on each tick, saturating at MAX_MS-1.
REQ-021 stop in RUN: go to DONE; reaction_ms = elapsed value before any same-cycle increment; stop takes priority over tick.
REQ-022 In RUN with no stop, when elapsed equals the latched timeout: go to DONE with timed_out=1 and reaction_ms=timeout; a latched timeout of 0 times out one cycle after entering RUN.
REQ-023 stop in WAIT: go to DONE with early=1 and reaction_ms=0.
REQ-024 stop in IDLE or DONE is ignored.
REQ-025 done pulses exactly once per trial, in the first DONE cycle; results hold until the next accepted start or reset.
REQ-026 early and timed_out are never both 1.
REQ-027 Outputs are registered; stimulus deasserts in the same cycle that done asserts.

Reset
REQ-028 reset_n low asynchronously forces IDLE and clears the prescaler, all counters, stimulus, busy, done, early, timed_out and reaction_ms to 0.
REQ-029 best_ms resets to MAX_MS-1 when REACTION_TIMER_BEST_EN is defined, and to 0 when it is not.
REQ-030 reset_n asserted mid-trial aborts the trial without a done pulse.

Configuration
REQ-031 With macro REACTION_TIMER_BEST_EN defined: on each DONE entry that has neither early nor timed_out set, best_ms <= min(best_ms, reaction_ms) in the same cycle as done.
REQ-032 Without REACTION_TIMER_BEST_EN: no best-tracking logic exists and best_ms is constant 0.

Verification (CLKS_PER_MS=4, MAX_MS=100)
REQ-033 Normal trial: start with delay_ms=3, timeout_ms=50, stop 7 ticks after stimulus rises -> stimulus high for the RUN period, done pulses once, reaction_ms=7, early=0, timed_out=0.
REQ-034 Early press: start with delay_ms=5, stop at tick 2 of WAIT -> stimulus never rises, early=1, reaction_ms=0, done pulses once.
REQ-035 Timeout: start with delay_ms=0, timeout_ms=4, no stop -> RUN one cycle after start, timed_out=1, reaction_ms=4 at done.
REQ-036 Priority and ignore rules: stop coincident with tick at elapsed=9 -> reaction_ms=9; start pulsed during RUN -> no effect.
REQ-037 Reset mid-RUN: reset_n low with elapsed=6 -> all outputs 0 immediately, no done pulse; a following start with delay_ms=1 runs normally.
REQ-038 With REACTION_TIMER_BEST_EN: valid trials of 12, 8, 10 ms and then a timeout -> best_ms = 99, 12, 8, 8, 8.

Source files
------------

// File: rtl/reaction_timer_if.sv
// reaction_timer_if: control/result bundle for the reaction timer.
//   start, stop          : one-cycle pulses, already synchronous to clk
//   delay_ms, timeout_ms : trial parameters, sampled on an accepted start
//   stimulus, busy, done : trial status (done is a one-cycle pulse)
//   early, timed_out     : held result flags
//   reaction_ms, best_ms : held measured time / best valid time
// master = stimulus side (drives start/stop), slave = the timer.
interface reaction_timer_if #(
    parameter int MAX_MS = 5000
) ();
    localparam int W = $clog2(MAX_MS);

    logic         start;
    logic         stop;
    logic [W-1:0] delay_ms;
    logic [W-1:0] timeout_ms;
    logic         stimulus;
    logic         busy;
    logic         done;
    logic         early;
    logic         timed_out;
    logic [W-1:0] reaction_ms;
    logic [W-1:0] best_ms;

    modport master (
        output start, stop, delay_ms, timeout_ms,
        input  stimulus, busy, done, early, timed_out, reaction_ms, best_ms
    );

    modport slave (
        input  start, stop, delay_ms, timeout_ms,
        output stimulus, busy, done, early, timed_out, reaction_ms, best_ms
    );
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer: measures player reaction time in milliseconds.
// A start pulse arms a trial: after delay_ms the stimulus is raised and the
// elapsed time is counted until stop (valid result), or until timeout_ms
// (timed_out). A stop before the stimulus ends the trial as early.
// Ports:
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : reaction_timer_if.slave (start/stop/parameters in, results out)
// Optional feature: define REACTION_TIMER_BEST_EN to track the best valid
// reaction time on best_ms; otherwise best_ms is tied to 0.
module reaction_timer #(
    parameter int MAX_MS      = 5000,
    parameter int CLKS_PER_MS = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    reaction_timer_if.slave  bus
);
    localparam int W  = $clog2(MAX_MS);
    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  dcnt_q, dcnt_d;
    logic [W-1:0]  elap_q, elap_d;
    logic [W-1:0]  tmo_q, tmo_d;
    logic          early_q, early_d;
    logic          tout_q, tout_d;
    logic [W-1:0]  react_q, react_d;
    logic          stim_q, busy_q, done_q;
    logic          tick;
    logic          valid_stop;

    assign tick = (presc_q == PW'(CLKS_PER_MS - 1));

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        dcnt_d     = dcnt_q;
        elap_d     = elap_q;
        tmo_d      = tmo_q;
        early_d    = early_q;
        tout_d     = tout_q;
        react_d    = react_q;
        valid_stop = 1'b0;

        // Prescaler only runs while a trial is active.
        if (state_q == WAIT || state_q == RUN)
            presc_d = tick ? '0 : presc_q + PW'(1);

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = WAIT;
                    dcnt_d  = bus.delay_ms;
                    tmo_d   = bus.timeout_ms;
                    early_d = 1'b0;
                    tout_d  = 1'b0;
                    react_d = '0;
                    elap_d  = '0;
                    presc_d = '0;
                end
            end
            WAIT: begin
                if (bus.stop) begin
                    state_d = DONE;
                    early_d = 1'b1;
                    react_d = '0;
                    presc_d = '0;
                end else if (dcnt_q == '0 || (tick && dcnt_q == W'(1))) begin
                    // Zero delay falls straight through after one WAIT cycle.
                    state_d = RUN;
                    elap_d  = '0;
                    presc_d = '0;
                end else if (tick) begin
                    dcnt_d = dcnt_q - W'(1);
                end
            end
            RUN: begin
                // stop wins over a same-cycle tick: report the pre-tick value.
                if (bus.stop) begin
                    state_d    = DONE;
                    react_d    = elap_q;
                    valid_stop = 1'b1;
                end else if (elap_q == tmo_q) begin
                    state_d = DONE;
                    tout_d  = 1'b1;
                    react_d = tmo_q;
                end else if (tick && elap_q != W'(MAX_MS - 1)) begin
                    elap_d = elap_q + W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // state_q; stimulus drops on the same edge that raises done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            dcnt_q  <= '0;
            elap_q  <= '0;
            tmo_q   <= '0;
            early_q <= 1'b0;
            tout_q  <= 1'b0;
            react_q <= '0;
            stim_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            dcnt_q  <= dcnt_d;
            elap_q  <= elap_d;
            tmo_q   <= tmo_d;
            early_q <= early_d;
            tout_q  <= tout_d;
            react_q <= react_d;
            stim_q  <= (state_d == RUN);
            busy_q  <= (state_d == WAIT) || (state_d == RUN);
            done_q  <= (state_d == DONE) && (state_q != DONE);
        end
    end

`ifdef REACTION_TIMER_BEST_EN
    logic [W-1:0] best_q;

    // Only trials ended by a stop in RUN are valid candidates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            best_q <= W'(MAX_MS - 1);
        else if (valid_stop && elap_q < best_q)
            best_q <= elap_q;
    end

    assign bus.best_ms = best_q;
`else
    logic unused_valid;
    assign unused_valid = valid_stop;
    assign bus.best_ms  = '0;
`endif

    assign bus.stimulus    = stim_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.early       = early_q;
    assign bus.timed_out   = tout_q;
    assign bus.reaction_ms = react_q;
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed checks of reaction_timer with CLKS_PER_MS=4,
// MAX_MS=100 (one ms tick every 4 clocks).
module tb_reaction_timer;
    localparam int MAX_MS = 100;
    localparam int CPM    = 4;
    localparam int W      = $clog2(MAX_MS);
`ifdef REACTION_TIMER_BEST_EN
    localparam bit BEST = 1'b1;
`else
    localparam bit BEST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   ncmp = 0;
    int   nerr = 0;

    reaction_timer_if #(.MAX_MS(MAX_MS)) bus ();

    reaction_timer #(.MAX_MS(MAX_MS), .CLKS_PER_MS(CPM)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one trial. n counts negedges after the start pulse was driven.
    // stop_n: drive stop at negedge n; stop_s/start_s: drive stop/start at
    // that many negedges after stimulus was first seen (-1 = never).
    task automatic trial(input int dly, input int tmo, input int stop_n,
                         input int stop_s, input int start_s,
                         output int t_stim, output int t_done, output int s_cnt);
        t_stim = -1; t_done = -1; s_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.delay_ms = W'(dly);
        bus.timeout_ms = W'(tmo);
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.stop = 1'b0;
            if (bus.done) begin
                t_done = n;
                break;
            end
            if (bus.stimulus) begin
                s_cnt++;
                if (t_stim < 0) t_stim = n;
            end
            if (n == stop_n) bus.stop = 1'b1;
            if (t_stim >= 0 && n - t_stim == stop_s) bus.stop = 1'b1;
            if (t_stim >= 0 && n - t_stim == start_s) bus.start = 1'b1;
        end
    endtask

    initial begin
        int ts, td, sc;
        logic seen_done;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.delay_ms = '0;
        bus.timeout_ms = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_stim", bus.stimulus, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_react", bus.reaction_ms, 0);
        chk("rst_best", bus.best_ms, BEST ? 99 : 0);
        reset_n = 1'b1;

        // stop in IDLE is ignored
        @(negedge clk); bus.stop = 1'b1;
        @(negedge clk); bus.stop = 1'b0;
        @(negedge clk);
        chk("idle_stop_busy", bus.busy, 0);
        chk("idle_stop_early", bus.early, 0);
        chk("idle_stop_done", bus.done, 0);

        // Normal trial: delay 3, stop when elapsed = 7
        trial(3, 50, -1, 28, -1, ts, td, sc);
        chk("norm_t_stim", ts, 13);
        chk("norm_t_done", td, 42);
        chk("norm_stim_cnt", sc, 29);
        chk("norm_stim_at_done", bus.stimulus, 0);
        chk("norm_react", bus.reaction_ms, 7);
        chk("norm_early", bus.early, 0);
        chk("norm_tout", bus.timed_out, 0);
        chk("norm_busy", bus.busy, 0);
        chk("norm_best", bus.best_ms, BEST ? 7 : 0);
        bus.stop = 1'b1;                       // stop in DONE is ignored
        @(negedge clk); bus.stop = 1'b0;
        chk("norm_done_once", bus.done, 0);
        @(negedge clk);
        chk("done_stop_react", bus.reaction_ms, 7);
        chk("done_stop_done", bus.done, 0);
        chk("done_stop_early", bus.early, 0);

        // Early press at the second ms tick of WAIT
        trial(5, 50, 8, -1, -1, ts, td, sc);
        chk("early_t_stim", ts, -1);
        chk("early_t_done", td, 9);
        chk("early_flag", bus.early, 1);
        chk("early_tout", bus.timed_out, 0);
        chk("early_react", bus.reaction_ms, 0);
        chk("early_best", bus.best_ms, BEST ? 7 : 0);
        @(negedge clk);
        chk("early_done_once", bus.done, 0);

        // Timeout, zero delay
        trial(0, 4, -1, -1, -1, ts, td, sc);
        chk("tmo_t_stim", ts, 2);
        chk("tmo_t_done", td, 19);
        chk("tmo_stim_cnt", sc, 17);
        chk("tmo_flag", bus.timed_out, 1);
        chk("tmo_early", bus.early, 0);
        chk("tmo_react", bus.reaction_ms, 4);
        @(negedge clk);
        chk("tmo_done_once", bus.done, 0);

        // stop coincident with tick at elapsed 9; start pulsed in RUN ignored
        trial(2, 50, -1, 39, 10, ts, td, sc);
        chk("prio_t_stim", ts, 9);
        chk("prio_t_done", td, 49);
        chk("prio_stim_cnt", sc, 40);
        chk("prio_react", bus.reaction_ms, 9);
        chk("prio_tout", bus.timed_out, 0);

        // Reset mid-RUN at elapsed 6
        @(negedge clk);
        bus.start = 1'b1; bus.delay_ms = W'(1); bus.timeout_ms = W'(50);
        @(negedge clk); bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_stim", bus.stimulus, 1);
        repeat (24) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_stim", bus.stimulus, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_react", bus.reaction_ms, 0);
        chk("mid_rst_tout", bus.timed_out, 0);
        seen_done = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        chk("mid_no_done", seen_done, 0);
        trial(1, 50, -1, 8, -1, ts, td, sc);
        chk("post_t_stim", ts, 5);
        chk("post_t_done", td, 14);
        chk("post_react", bus.reaction_ms, 2);

        // Best tracking: 12, 8, 10 ms then a timeout
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        chk("best_rst", bus.best_ms, BEST ? 99 : 0);
        trial(0, 50, -1, 48, -1, ts, td, sc);
        chk("best12_react", bus.reaction_ms, 12);
        chk("best12", bus.best_ms, BEST ? 12 : 0);
        trial(0, 50, -1, 32, -1, ts, td, sc);
        chk("best8_react", bus.reaction_ms, 8);
        chk("best8", bus.best_ms, BEST ? 8 : 0);
        trial(0, 50, -1, 40, -1, ts, td, sc);
        chk("best10_react", bus.reaction_ms, 10);
        chk("best10", bus.best_ms, BEST ? 8 : 0);
        trial(0, 3, -1, -1, -1, ts, td, sc);
        chk("best_tmo_flag", bus.timed_out, 1);
        chk("best_tmo", bus.best_ms, BEST ? 8 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
